// File: rtl/uart_pkg.sv
// Shared definitions for the hex-word UART transmit path: ASCII constants,
// FSM state encodings and the nibble-to-ASCII helper.
package uart_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned IDX_W  = 3;

  localparam logic [BYTE_W-1:0] CHAR_CR = 8'h0D;
  localparam logic [BYTE_W-1:0] CHAR_LF = 8'h0A;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {F_IDLE, F_LOAD, F_WAIT} frame_state_t;

  // 0-9 -> '0'-'9', A-F -> 'A'-'F' (uppercase only); 8'h37 is 'A' minus ten
  function automatic logic [BYTE_W-1:0] nibble_to_ascii(input logic [3:0] nib);
    if (nib < 4'd10) return 8'h30 + {4'h0, nib};
    else             return 8'h37 + {4'h0, nib};
  endfunction

endpackage

// File: rtl/hex_word_uart_tx_if.sv
// Handshake/serial bundle between the display-word source and the transmitter.
//   send : request to transmit data (source -> transmitter)
//   data : 16-bit display word (source -> transmitter)
//   busy : frame in progress (transmitter -> source)
//   done : one-cycle pulse after the last stop bit (transmitter -> source)
//   tx   : serial line, idles high (transmitter -> line)
interface hex_word_uart_tx_if;
  import uart_pkg::*;

  logic              send;
  logic [DATA_W-1:0] data;
  logic              busy;
  logic              done;
  logic              tx;

  modport master (output send, output data, input busy, input done, input tx);
  modport slave  (input send, input data, output busy, output done, output tx);

endinterface

// File: rtl/uart_tx_byte.sv
// 8N1 byte serialiser: start bit, 8 data bits LSB first, stop bit, each
// CLKS_PER_BIT cycles long.
//   clk, reset   : clock, synchronous active-high reset
//   start        : begin a byte when idle (din captured on that edge)
//   din          : byte to send
//   tx           : serial line, idles high
//   tx_done_tick : high during the final cycle of the stop bit
module uart_tx_byte
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 10416
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [BYTE_W-1:0] din,
  output logic              tx,
  output logic              tx_done_tick
);

  localparam int unsigned      CNT_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  tx_state_t         state, state_d;
  logic [CNT_W-1:0]  cnt, cnt_d;
  logic [2:0]        bit_cnt, bit_cnt_d;
  logic [BYTE_W-1:0] shreg, shreg_d;
  logic              tx_d;
  logic              tick_d;

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= TX_IDLE;
      cnt          <= '0;
      bit_cnt      <= '0;
      shreg        <= '0;
      tx           <= 1'b1;
      tx_done_tick <= 1'b0;
    end else begin
      state        <= state_d;
      cnt          <= cnt_d;
      bit_cnt      <= bit_cnt_d;
      shreg        <= shreg_d;
      tx           <= tx_d;
      tx_done_tick <= tick_d;
    end
  end

  // Next-state and registered-output decode
  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    bit_cnt_d = bit_cnt;
    shreg_d   = shreg;

    case (state)
      TX_IDLE: begin
        if (start) begin
          state_d = TX_START;
          cnt_d   = '0;
          shreg_d = din;
        end
      end
      TX_START: begin
        if (cnt == CNT_LAST) begin
          state_d   = TX_DATA;
          cnt_d     = '0;
          bit_cnt_d = '0;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      TX_DATA: begin
        if (cnt == CNT_LAST) begin
          cnt_d   = '0;
          shreg_d = shreg >> 1;
          if (bit_cnt == 3'd7) begin
            state_d = TX_STOP;
          end else begin
            bit_cnt_d = bit_cnt + 3'd1;
          end
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      TX_STOP: begin
        if (cnt == CNT_LAST) begin
          state_d = TX_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      default: state_d = TX_IDLE;
    endcase

    // Line level follows the state being entered so tx is a clean register
    tx_d = 1'b1;
    if (state_d == TX_START)     tx_d = 1'b0;
    else if (state_d == TX_DATA) tx_d = shreg_d[0];

    // Raised one cycle early so the framer can react exactly as the stop bit ends
    tick_d = (state_d == TX_STOP) && (cnt_d == CNT_LAST);
  end

endmodule

// File: rtl/hex_word_uart_tx.sv
// Sends a 16-bit display word as four uppercase ASCII hex characters,
// optionally followed by CR LF, over an 8N1 serial line.
//   clk, reset : clock, synchronous active-high reset
//   bus        : slave side of hex_word_uart_tx_if (send/data in,
//                busy/done/tx out)
module hex_word_uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 10416,
  parameter bit          APPEND_CRLF  = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  hex_word_uart_tx_if.slave bus
);

  localparam logic [IDX_W-1:0] LAST_IDX = APPEND_CRLF ? 3'd5 : 3'd3;

  frame_state_t      state, state_d;
  logic [IDX_W-1:0]  idx, idx_d;
  logic [DATA_W-1:0] hold, hold_d;
  logic              start_q, start_d;
  logic              busy, busy_d;
  logic              done, done_d;
  logic [BYTE_W-1:0] char_c;
  logic              byte_tick;
  logic              tx_line;

  assign bus.busy = busy;
  assign bus.done = done;
  assign bus.tx   = tx_line;

  // Character select: four nibbles MSB first, then CR, LF
  always_comb begin
    char_c = '0;
    case (idx)
      3'd0:    char_c = nibble_to_ascii(hold[15:12]);
      3'd1:    char_c = nibble_to_ascii(hold[11:8]);
      3'd2:    char_c = nibble_to_ascii(hold[7:4]);
      3'd3:    char_c = nibble_to_ascii(hold[3:0]);
      3'd4:    char_c = CHAR_CR;
      3'd5:    char_c = CHAR_LF;
      default: char_c = '0;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= F_IDLE;
      idx     <= '0;
      hold    <= '0;
      start_q <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_d;
      idx     <= idx_d;
      hold    <= hold_d;
      start_q <= start_d;
      busy    <= busy_d;
      done    <= done_d;
    end
  end

  // Framing FSM: LOAD issues a registered start, so every character
  // (including the first) begins its start bit two edges after LOAD is entered
  always_comb begin
    state_d = state;
    idx_d   = idx;
    hold_d  = hold;
    start_d = 1'b0;
    done_d  = 1'b0;

    case (state)
      F_IDLE: begin
        if (bus.send) begin
          hold_d  = bus.data;
          idx_d   = '0;
          state_d = F_LOAD;
        end
      end
      F_LOAD: begin
        start_d = 1'b1;
        state_d = F_WAIT;
      end
      F_WAIT: begin
        if (byte_tick) begin
          if (idx == LAST_IDX) begin
            idx_d   = '0;
            done_d  = 1'b1;
            state_d = F_IDLE;
          end else begin
            idx_d   = idx + 3'd1;
            state_d = F_LOAD;
          end
        end
      end
      default: state_d = F_IDLE;
    endcase

    busy_d = (state_d != F_IDLE);
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx_byte (
    .clk         (clk),
    .reset       (reset),
    .start       (start_q),
    .din         (char_c),
    .tx          (tx_line),
    .tx_done_tick(byte_tick)
  );

endmodule

// File: tb/tb_hex_word_uart_tx.sv
// Directed bench for hex_word_uart_tx at 4 clocks per bit. A CRLF instance
// and a digits-only instance share clk/reset; tx is decoded per bit and each
// character's start cycle is checked against the acceptance edge.
module tb_hex_word_uart_tx;

  localparam int CPB      = 4;
  localparam int CHAR_CYC = 10 * CPB + 2;

  logic clk = 1'b0;
  logic reset;
  int   cyc      = 0;
  int   checks   = 0;
  int   errors   = 0;
  int   done_cnt = 0;

  hex_word_uart_tx_if bus ();
  hex_word_uart_tx_if bus_nc ();

  hex_word_uart_tx #(.CLKS_PER_BIT(CPB), .APPEND_CRLF(1'b1)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  hex_word_uart_tx #(.CLKS_PER_BIT(CPB), .APPEND_CRLF(1'b0)) dut_nc (
    .clk  (clk),
    .reset(reset),
    .bus  (bus_nc.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) if (bus.done === 1'b1) done_cnt <= done_cnt + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic tx_of(input bit nc);
    return nc ? bus_nc.tx : bus.tx;
  endfunction

  function automatic logic done_of(input bit nc);
    return nc ? bus_nc.done : bus.done;
  endfunction

  function automatic logic busy_of(input bit nc);
    return nc ? bus_nc.busy : bus.busy;
  endfunction

  // Drive one send pulse (or leave send high); acc = cycle count just after the acceptance edge
  task automatic start_send(input bit nc, input logic [15:0] d, input bit keep, output int acc);
    if (nc) begin bus_nc.send = 1'b1; bus_nc.data = d; end
    else    begin bus.send    = 1'b1; bus.data    = d; end
    @(negedge clk);
    acc = cyc;
    if (!keep) begin
      if (nc) bus_nc.send = 1'b0;
      else    bus.send    = 1'b0;
    end
  endtask

  // Wait for a start bit, then sample all 10 bits, checking each holds for CPB cycles
  task automatic rx_byte(input bit nc, input string tag, input logic [7:0] exp, input int exp_start);
    int         n = 0;
    logic [9:0] bits = '0;
    bit         width_ok = 1'b1;
    logic       v;
    while (tx_of(nc) !== 1'b0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) begin
      check({tag, "_timeout"}, 32'(n), 32'(0));
      return;
    end
    check({tag, "_start_cyc"}, 32'(cyc), 32'(exp_start));
    for (int b = 0; b < 10; b++) begin
      v       = tx_of(nc);
      bits[b] = v;
      for (int c = 0; c < CPB; c++) begin
        if (tx_of(nc) !== v) width_ok = 1'b0;
        @(negedge clk);
      end
    end
    check({tag, "_framing"}, 32'({bits[9], bits[0]}), 32'(2'b10));
    check({tag, "_data"}, 32'(bits[8:1]), 32'(exp));
    check({tag, "_bit_width"}, 32'(width_ok), 32'(1));
  endtask

  // Receive n characters (exp packed MSB-first, right-aligned); optionally poke a
  // rejected send mid-frame. Returns in the done cycle.
  task automatic rx_frame(input bit nc, input string tag, input logic [47:0] exp,
                          input int n, input int acc, input bit poke);
    for (int i = 0; i < n; i++) begin
      rx_byte(nc, $sformatf("%s_c%0d", tag, i), exp[8*(n-1-i) +: 8], acc + 2 + CHAR_CYC * i);
      if (poke && i == 1) begin
        bus.send = 1'b1;
        bus.data = 16'hBEEF;
        @(negedge clk);
        bus.send = 1'b0;
      end
    end
    check({tag, "_done"}, 32'(done_of(nc)), 32'(1));
    check({tag, "_busy_in_done"}, 32'(busy_of(nc)), 32'(0));
    check({tag, "_done_cyc"}, 32'(cyc), 32'(acc + CHAR_CYC * n));
  endtask

  initial begin
    int acc;
    int dc0;
    int n;
    bit ok;

    reset       = 1'b1;
    bus.send    = 1'b0;
    bus.data    = '0;
    bus_nc.send = 1'b0;
    bus_nc.data = '0;

    // Reset and idle
    repeat (3) @(negedge clk);
    check("rst_tx", 32'(bus.tx), 32'(1));
    check("rst_busy", 32'(bus.busy), 32'(0));
    check("rst_done", 32'(bus.done), 32'(0));
    reset = 1'b0;
    ok = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.tx !== 1'b1 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus_nc.tx !== 1'b1) ok = 1'b0;
    end
    check("idle_50", 32'(ok), 32'(1));

    // Single word
    start_send(1'b0, 16'h1A3F, 1'b0, acc);
    check("accept_busy", 32'(bus.busy), 32'(1));
    rx_frame(1'b0, "w1A3F", 48'h31_41_33_46_0D_0A, 6, acc, 1'b0);
    @(negedge clk);
    check("w1A3F_done_one_cycle", 32'(bus.done), 32'(0));
    check("w1A3F_done_count", 32'(done_cnt), 32'(1));

    // Boundary words
    start_send(1'b0, 16'h0000, 1'b0, acc);
    rx_frame(1'b0, "w0000", 48'h30_30_30_30_0D_0A, 6, acc, 1'b0);
    @(negedge clk);
    start_send(1'b0, 16'hFFFF, 1'b0, acc);
    rx_frame(1'b0, "wFFFF", 48'h46_46_46_46_0D_0A, 6, acc, 1'b0);
    @(negedge clk);

    // Digits-only instance
    start_send(1'b1, 16'h9C05, 1'b0, acc);
    rx_frame(1'b1, "nc9C05", 48'h00_00_39_43_30_35, 4, acc, 1'b0);
    ok = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (bus_nc.tx !== 1'b1 || bus_nc.busy !== 1'b0) ok = 1'b0;
    end
    check("nc_no_extra_chars", 32'(ok), 32'(1));

    // Busy rejection with data changed mid-frame
    dc0 = done_cnt;
    start_send(1'b0, 16'h1234, 1'b0, acc);
    rx_frame(1'b0, "w1234", 48'h31_32_33_34_0D_0A, 6, acc, 1'b1);
    ok = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (bus.tx !== 1'b1 || bus.busy !== 1'b0) ok = 1'b0;
    end
    check("reject_no_frame", 32'(ok), 32'(1));
    check("reject_done_count", 32'(done_cnt - dc0), 32'(1));

    // Back-to-back with send held high; new word presented in the done cycle
    start_send(1'b0, 16'h00AB, 1'b1, acc);
    rx_frame(1'b0, "w00AB", 48'h30_30_41_42_0D_0A, 6, acc, 1'b0);
    bus.data = 16'hCD00;
    @(negedge clk);
    acc = cyc;
    bus.send = 1'b0;
    check("b2b_accept_busy", 32'(bus.busy), 32'(1));
    rx_frame(1'b0, "wCD00", 48'h43_44_30_30_0D_0A, 6, acc, 1'b0);
    @(negedge clk);

    // Reset during the data bits of the third character
    start_send(1'b0, 16'h5A5A, 1'b0, acc);
    rx_byte(1'b0, "rst5A_c0", 8'h35, acc + 2);
    rx_byte(1'b0, "rst5A_c1", 8'h41, acc + 2 + CHAR_CYC);
    n = 0;
    while (bus.tx !== 1'b0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("rst5A_c2_start_cyc", 32'(cyc), 32'(acc + 2 + 2 * CHAR_CYC));
    repeat (CPB + 2 * CPB + 1) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_tx", 32'(bus.tx), 32'(1));
    check("midrst_busy", 32'(bus.busy), 32'(0));
    reset = 1'b0;
    ok = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (bus.tx !== 1'b1 || bus.busy !== 1'b0 || bus.done !== 1'b0) ok = 1'b0;
    end
    check("midrst_quiet", 32'(ok), 32'(1));
    start_send(1'b0, 16'h7777, 1'b0, acc);
    rx_frame(1'b0, "w7777", 48'h37_37_37_37_0D_0A, 6, acc, 1'b0);
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
